// File: rtl/rtc_seq_pkg.sv
// Shared state encoding and default widths for the RTC sample sequencer.
package rtc_seq_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int SETTLE_W_DEF   = 16;
  localparam int TMO_W_DEF      = 16;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t PWR  = 2'd1;
  localparam state_t REQ  = 2'd2;
  localparam state_t HOLD = 2'd3;

endpackage

// File: rtl/rtc_trig_divider.sv
// Rising-edge detect on the RTC alarm level plus an alarm-count divider.
// sample_due is a combinational 1-cycle pulse on the alarm that completes a group.
module rtc_trig_divider (
  input  logic       clk,
  input  logic       rst,
  input  logic       rtc_trig,
  input  logic       enable,
  input  logic [7:0] interval,
  output logic       sample_due
);

  logic       trig_q;
  logic [7:0] div;
  logic       rise;
  logic [7:0] eff_interval;
  logic       wrap;

  assign rise         = rtc_trig & ~trig_q;
  assign eff_interval = (interval == 8'd0) ? 8'd1 : interval;
  // Widen by one bit so div+1 cannot overflow past 255.
  assign wrap         = ({1'b0, div} + 9'd1) >= {1'b0, eff_interval};
  assign sample_due   = rise & enable & wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_q <= 1'b0;
      div    <= 8'd0;
    end else begin
      trig_q <= rtc_trig;
      if (!enable) begin
        div <= 8'd0;
      end else if (rise) begin
        div <= wrap ? 8'd0 : div + 8'd1;
      end
    end
  end

endmodule

// File: rtl/rtc_sample_sequencer.sv
// Power/settle/request/hold sequencer fed by the RTC alarm divider.
// Optional ack timeout in REQ is enabled by defining SEQ_TIMEOUT_EN.
module rtc_sample_sequencer
  import rtc_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SETTLE_W   = SETTLE_W_DEF,
  parameter int TMO_W      = TMO_W_DEF
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  rtc_trig,
  input  logic                  cfg_enable,
  input  logic [7:0]            cfg_interval,
  input  logic [SETTLE_W-1:0]   cfg_settle,
  input  logic [TMO_W-1:0]      cfg_timeout,
  input  logic                  clr_status,
  output logic                  sensor_pwr_en,
  output logic                  sample_req,
  input  logic                  sample_ack,
  input  logic [DATA_WIDTH-1:0] sample_data,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [DATA_WIDTH-1:0] result_data,
  output logic                  done_intr,
  output logic                  busy,
  output logic                  overrun,
  output logic                  timeout
);

  state_t              state;
  state_t              state_nxt;
  logic                sample_due;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                tmo_expire;

  rtc_trig_divider u_div (
    .clk        (PCLK),
    .rst        (PRESET),
    .rtc_trig   (rtc_trig),
    .enable     (cfg_enable),
    .interval   (cfg_interval),
    .sample_due (sample_due)
  );

`ifdef SEQ_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;

  // An ack in the expiry cycle still wins.
  assign tmo_expire = (state == REQ) && !sample_ack && (tmo_cnt == '0);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tmo_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      if (state == PWR && settle_cnt == '0) begin
        tmo_cnt <= cfg_timeout;
      end else if (state == REQ && tmo_cnt != '0) begin
        tmo_cnt <= tmo_cnt - 1'b1;
      end
      if (tmo_expire) begin
        timeout <= 1'b1;
      end else if (clr_status) begin
        timeout <= 1'b0;
      end
    end
  end
`else
  logic unused_tmo;

  assign unused_tmo = ^cfg_timeout;
  assign tmo_expire = 1'b0;
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (sample_due) state_nxt = PWR;
      PWR:  if (settle_cnt == '0) state_nxt = REQ;
      REQ: begin
        if (sample_ack) begin
          state_nxt = HOLD;
        end else if (tmo_expire) begin
          state_nxt = IDLE;
        end
      end
      HOLD: if (result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sensor_pwr_en = (state == PWR) || (state == REQ);
    sample_req    = (state == REQ);
    result_valid  = (state == HOLD);
    busy          = (state != IDLE);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      settle_cnt  <= '0;
      result_data <= '0;
      done_intr   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (state == IDLE && sample_due) begin
        settle_cnt <= cfg_settle;
      end else if (state == PWR && settle_cnt != '0) begin
        settle_cnt <= settle_cnt - 1'b1;
      end
      if (state == REQ && sample_ack) begin
        result_data <= sample_data;
      end
      done_intr <= (state == HOLD) && result_ready;
      // A due sample with the sequencer busy is dropped, not queued.
      if (sample_due && state != IDLE) begin
        overrun <= 1'b1;
      end else if (clr_status) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rtc_sample_sequencer.sv
// Directed table-driven bench for rtc_sample_sequencer plus hand-written corner sequences.
// Define SEQ_TIMEOUT_EN for both bench and RTL to exercise the ack timeout.
module tb_rtc_sample_sequencer;

  logic        PCLK;
  logic        PRESET;
  logic        rtc_trig;
  logic        cfg_enable;
  logic [7:0]  cfg_interval;
  logic [15:0] cfg_settle;
  logic [15:0] cfg_timeout;
  logic        clr_status;
  logic        sensor_pwr_en;
  logic        sample_req;
  logic        sample_ack;
  logic [31:0] sample_data;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] result_data;
  logic        done_intr;
  logic        busy;
  logic        overrun;
  logic        timeout;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [7:0]  interval;
    logic [15:0] settle;
    logic [31:0] data;
    int          hold_cycles;
  } vec_t;

  vec_t vecs[4];

  rtc_sample_sequencer dut (
    .PCLK          (PCLK),
    .PRESET        (PRESET),
    .rtc_trig      (rtc_trig),
    .cfg_enable    (cfg_enable),
    .cfg_interval  (cfg_interval),
    .cfg_settle    (cfg_settle),
    .cfg_timeout   (cfg_timeout),
    .clr_status    (clr_status),
    .sensor_pwr_en (sensor_pwr_en),
    .sample_req    (sample_req),
    .sample_ack    (sample_ack),
    .sample_data   (sample_data),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .result_data   (result_data),
    .done_intr     (done_intr),
    .busy          (busy),
    .overrun       (overrun),
    .timeout       (timeout)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pulse_trig();
    rtc_trig = 1'b1;
    tick();
    rtc_trig = 1'b0;
  endtask

  task automatic wait_req(input int max);
    int k;
    k = 0;
    while (!sample_req && k < max) begin
      tick();
      k++;
    end
    check("wait_req", {31'd0, sample_req}, 32'd1);
  endtask

  task automatic ack_and_accept(input logic [31:0] data);
    sample_data = data;
    sample_ack  = 1'b1;
    tick();
    sample_ack  = 1'b0;
    check("hold_valid", {31'd0, result_valid}, 32'd1);
    check("hold_data", result_data, data);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("accept_done", {31'd0, done_intr}, 32'd1);
    check("accept_idle", {31'd0, busy}, 32'd0);
    tick();
    check("done_one_cycle", {31'd0, done_intr}, 32'd0);
  endtask

  initial begin
    int pulses;
    int done_cnt;
    vec_t v;

    n_tests = 0;
    n_fail  = 0;
    vecs[0] = '{interval: 8'd3, settle: 16'd4, data: 32'hA5A5_0001, hold_cycles: 10};
    vecs[1] = '{interval: 8'd1, settle: 16'd0, data: 32'h0000_1234, hold_cycles: 0};
    vecs[2] = '{interval: 8'd0, settle: 16'd2, data: 32'hDEAD_BEEF, hold_cycles: 1};
    vecs[3] = '{interval: 8'd2, settle: 16'd1, data: 32'h5A5A_F00F, hold_cycles: 3};

    PRESET       = 1'b1;
    rtc_trig     = 1'b0;
    cfg_enable   = 1'b1;
    cfg_interval = 8'd1;
    cfg_settle   = 16'd0;
    cfg_timeout  = 16'd50;
    clr_status   = 1'b0;
    sample_ack   = 1'b0;
    sample_data  = 32'h0;
    result_ready = 1'b0;
    repeat (3) tick();
    PRESET = 1'b0;
    check("rst_outputs", {25'd0, sensor_pwr_en, sample_req, result_valid, done_intr,
                          busy, overrun, timeout}, 32'd0);
    check("rst_data", result_data, 32'd0);

    // Table: full sample cycles at several interval/settle/backpressure settings.
    for (int r = 0; r < 4; r++) begin
      v = vecs[r];
      cfg_interval = v.interval;
      cfg_settle   = v.settle;
      pulses = (v.interval == 8'd0) ? 1 : int'(v.interval);
      for (int p = 0; p < pulses; p++) begin
        check("pwr_before_last_rise", {31'd0, sensor_pwr_en}, 32'd0);
        pulse_trig();
        if (p < pulses - 1) tick();
      end
      check("pwr_after_rise", {31'd0, sensor_pwr_en}, 32'd1);
      check("busy_in_pwr", {31'd0, busy}, 32'd1);
      for (int s = 0; s <= int'(v.settle); s++) begin
        check("req_during_settle", {31'd0, sample_req}, 32'd0);
        tick();
      end
      check("req_after_settle", {31'd0, sample_req}, 32'd1);
      check("pwr_in_req", {31'd0, sensor_pwr_en}, 32'd1);
      sample_data = v.data;
      sample_ack  = 1'b1;
      tick();
      sample_ack  = 1'b0;
      sample_data = $urandom_range(32'hFFFF, 0);
      check("valid_in_hold", {31'd0, result_valid}, 32'd1);
      check("data_in_hold", result_data, v.data);
      check("pwr_off_hold", {30'd0, sensor_pwr_en, sample_req}, 32'd0);
      for (int h = 0; h < v.hold_cycles; h++) begin
        tick();
        check("hold_stable", {31'd0, result_valid}, 32'd1);
        check("hold_data_stable", result_data, v.data);
        check("no_done_in_hold", {31'd0, done_intr}, 32'd0);
      end
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      check("done_pulse", {31'd0, done_intr}, 32'd1);
      check("valid_drop", {31'd0, result_valid}, 32'd0);
      check("idle_after", {31'd0, busy}, 32'd0);
      tick();
      check("done_cleared", {31'd0, done_intr}, 32'd0);
    end

    // Disabled: alarms ignored and a partial group count is discarded.
    cfg_enable = 1'b0;
    cfg_interval = 8'd1;
    repeat (3) begin
      pulse_trig();
      tick();
      check("disabled_no_cycle", {31'd0, busy}, 32'd0);
    end
    cfg_enable   = 1'b1;
    cfg_interval = 8'd2;
    pulse_trig();
    tick();
    cfg_enable = 1'b0;
    tick();
    cfg_enable = 1'b1;
    pulse_trig();
    tick();
    check("div_cleared_by_disable", {31'd0, busy}, 32'd0);
    pulse_trig();
    check("second_rise_fires", {31'd0, sensor_pwr_en}, 32'd1);
    wait_req(20);
    ack_and_accept(32'h1111_2222);

    // Overrun: a due sample while in REQ is dropped, cycle still completes.
    cfg_interval = 8'd1;
    cfg_settle   = 16'd1;
    pulse_trig();
    wait_req(20);
    pulse_trig();
    check("overrun_set", {31'd0, overrun}, 32'd1);
    check("req_not_aborted", {31'd0, sample_req}, 32'd1);
    ack_and_accept(32'h0BAD_CAFE);
    check("overrun_sticky", {31'd0, overrun}, 32'd1);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("overrun_cleared", {31'd0, overrun}, 32'd0);

    // Level held high for 100 cycles counts as a single alarm.
    cfg_settle = 16'd2;
    done_cnt = 0;
    rtc_trig = 1'b1;
    for (int i = 0; i < 100; i++) begin
      sample_ack   = sample_req;
      sample_data  = 32'h0000_0100 + i;
      result_ready = 1'b1;
      tick();
      if (done_intr) done_cnt++;
    end
    rtc_trig     = 1'b0;
    sample_ack   = 1'b0;
    result_ready = 1'b0;
    tick();
    check("held_level_one_cycle", done_cnt, 32'd1);
    check("held_level_no_overrun", {31'd0, overrun}, 32'd0);
    check("held_level_idle", {31'd0, busy}, 32'd0);

`ifdef SEQ_TIMEOUT_EN
    cfg_settle  = 16'd0;
    cfg_timeout = 16'd8;
    done_cnt = 0;
    pulse_trig();
    wait_req(20);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done_intr) done_cnt++;
      check("req_waiting", {31'd0, sample_req}, 32'd1);
    end
    tick();
    if (done_intr) done_cnt++;
    check("tmo_req_pwr_low", {30'd0, sensor_pwr_en, sample_req}, 32'd0);
    check("tmo_flag", {31'd0, timeout}, 32'd1);
    check("tmo_no_result", {30'd0, result_valid, busy}, 32'd0);
    tick();
    if (done_intr) done_cnt++;
    check("tmo_no_done", done_cnt, 32'd0);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("tmo_cleared", {31'd0, timeout}, 32'd0);
    cfg_timeout = 16'd50;
`else
    cfg_settle = 16'd0;
    pulse_trig();
    wait_req(20);
    repeat (30) tick();
    check("req_waits_forever", {31'd0, sample_req}, 32'd1);
    check("timeout_tied_low", {31'd0, timeout}, 32'd0);
    ack_and_accept(32'h7777_8888);
`endif

    // Reset in REQ with a same-cycle ack: ack is discarded.
    cfg_settle = 16'd0;
    pulse_trig();
    wait_req(20);
    sample_data = 32'hFFFF_FFFF;
    sample_ack  = 1'b1;
    PRESET      = 1'b1;
    tick();
    PRESET      = 1'b0;
    sample_ack  = 1'b0;
    check("preset_outputs", {25'd0, sensor_pwr_en, sample_req, result_valid, done_intr,
                             busy, overrun, timeout}, 32'd0);
    check("preset_data", result_data, 32'd0);
    tick();
    check("preset_ack_discarded", {30'd0, result_valid, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
